sync_tx_arbiter: RTL and testbench



---
 rtl/sync_tx_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sync_tx_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_tx_arbiter.sv
// Round-robin source-domain scheduler for the pulse synchronizer: grants one requester, drives its
// word with a timed strobe and hold, then pulses done. Define SYNC_TX_XFER_CNT_EN to add xfer_count.
module sync_tx_arbiter #(
  parameter int unsigned N           = 8,
  parameter int unsigned NREQ        = 4,
  parameter int unsigned STB_CYCLES  = 2,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] req_data,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [N-1:0]      data_out,
  output logic              stb_out,
  output logic              busy
`ifdef SYNC_TX_XFER_CNT_EN
  ,
  output logic [15:0]       xfer_count
`endif
);

  localparam int unsigned PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_MAX = (STB_CYCLES > HOLD_CYCLES) ? STB_CYCLES : HOLD_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  win_q, win_d;
  logic [NREQ-1:0]   grant_d;
  logic [NREQ-1:0]   done_d;
  logic [N-1:0]      data_d;
  logic              stb_d;
  logic              busy_d;
`ifdef SYNC_TX_XFER_CNT_EN
  logic [15:0]       xfer_d;
`endif

  logic [N-1:0]      words [NREQ];
  logic              arb_found;
  logic [PTR_W-1:0]  arb_idx;
  logic [PTR_W-1:0]  cand_idx;
  int unsigned       cand;

  // Unpack the request words
  always_comb begin : unpack
    for (int i = 0; i < NREQ; i++) begin
      words[i] = req_data[i*N +: N];
    end
  end

  // First set request searching upward from the pointer, wrapping
  always_comb begin : arb
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand     = (32'(ptr_q) + 32'(k)) % NREQ;
      cand_idx = PTR_W'(cand);
      if (!arb_found && req[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin : next
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    grant_d = grant;
    done_d  = done;
    data_d  = data_out;
    stb_d   = stb_out;
    busy_d  = busy;
`ifdef SYNC_TX_XFER_CNT_EN
    xfer_d  = xfer_count;
`endif
    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          grant_d = NREQ'(1) << arb_idx;
          win_d   = arb_idx;
          data_d  = words[arb_idx];
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        stb_d   = 1'b1;
        cnt_d   = CNT_W'(STB_CYCLES - 1);
        state_d = S_STROBE;
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          stb_d   = 1'b0;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          done_d  = grant;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        grant_d = '0;
        done_d  = '0;
        busy_d  = 1'b0;
        ptr_d   = (win_q == PTR_W'(NREQ - 1)) ? '0 : win_q + PTR_W'(1);
        state_d = S_IDLE;
`ifdef SYNC_TX_XFER_CNT_EN
        xfer_d  = xfer_count + 16'd1;
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset dominates, ena low freezes everything
  always_ff @(posedge clk) begin : regs
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      win_q      <= '0;
      grant      <= '0;
      done       <= '0;
      data_out   <= '0;
      stb_out    <= 1'b0;
      busy       <= 1'b0;
`ifdef SYNC_TX_XFER_CNT_EN
      xfer_count <= 16'd0;
`endif
    end else if (ena) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      grant      <= grant_d;
      done       <= done_d;
      data_out   <= data_d;
      stb_out    <= stb_d;
      busy       <= busy_d;
`ifdef SYNC_TX_XFER_CNT_EN
      xfer_count <= xfer_d;
`endif
    end
  end

endmodule

// File: tb/tb_sync_tx_arbiter.sv
// Randomized scoreboard bench for sync_tx_arbiter: a round-robin order model predicts winners and
// words, a monitor checks per-transfer timing, freeze, reset and invariants.
module tb_sync_tx_arbiter;

  localparam int unsigned N          = 8;
  localparam int unsigned NREQ       = 4;
  localparam int unsigned STB        = 2;
  localparam int unsigned HOLD       = 4;
  localparam int unsigned XFER_EDGES = 1 + STB + HOLD;

  typedef struct packed {
    logic [7:0]   w;
    logic [N-1:0] word;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic [N-1:0]      data_out;
  logic              stb_out;
  logic              busy;
`ifdef SYNC_TX_XFER_CNT_EN
  logic [15:0]       xfer_count;
`endif

  sync_tx_arbiter #(.N(N), .NREQ(NREQ), .STB_CYCLES(STB), .HOLD_CYCLES(HOLD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .done     (done),
    .data_out (data_out),
    .stb_out  (stb_out),
    .busy     (busy)
`ifdef SYNC_TX_XFER_CNT_EN
    ,
    .xfer_count (xfer_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t        exp_q[$];
  bit          lat_armed = 1'b0;
  bit          rand_ena  = 1'b0;
  int unsigned mptr      = 0;
  int unsigned b_cnt  [NREQ];
  logic [N-1:0] b_word [NREQ][2];

  logic ena_q, rst_q;
  always @(posedge clk) begin
    ena_q <= ena;
    rst_q <= rst_n;
  end

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: pops the expected transfer at each grant and checks it edge by edge
  bit           in_flight = 1'b0;
  exp_t         cur;
  int unsigned  off;
  int unsigned  stb_cnt;
  logic [N-1:0] last_word = '0;
  int unsigned  xfer_model = 0;
  logic [NREQ-1:0] p_grant, p_done;
  logic [N-1:0]    p_data;
  logic            p_stb, p_busy;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_q === 1'b0) begin
        check_eq("reset_grant", 32'(grant), 0);
        check_eq("reset_done", 32'(done), 0);
        check_eq("reset_data", 32'(data_out), 0);
        check_eq("reset_stb", 32'(stb_out), 0);
        check_eq("reset_busy", 32'(busy), 0);
        in_flight  = 1'b0;
        last_word  = '0;
        xfer_model = 0;
      end else if (rst_q === 1'b1 && ena_q === 1'b0) begin
        check_eq("freeze_grant", 32'(grant), 32'(p_grant));
        check_eq("freeze_done", 32'(done), 32'(p_done));
        check_eq("freeze_data", 32'(data_out), 32'(p_data));
        check_eq("freeze_stb", 32'(stb_out), 32'(p_stb));
        check_eq("freeze_busy", 32'(busy), 32'(p_busy));
      end else if (rst_q === 1'b1) begin
        if (in_flight) begin
          off++;
          if (stb_out) stb_cnt++;
          if (off <= XFER_EDGES) begin
            check_eq("grant_hold", 32'(grant), 32'(NREQ'(1) << cur.w));
            check_eq("data_hold", 32'(data_out), 32'(cur.word));
            check_eq("busy_hold", 32'(busy), 1);
            check_eq("stb_window", 32'(stb_out), 32'(off <= STB));
            if (off == XFER_EDGES) begin
              check_eq("done_pulse", 32'(done), 32'(NREQ'(1) << cur.w));
              check_eq("stb_cycles", stb_cnt, STB);
            end else begin
              check_eq("done_early", 32'(done), 0);
            end
          end else begin
            xfer_model = xfer_model + 1;
            check_eq("end_grant", 32'(grant), 0);
            check_eq("end_done", 32'(done), 0);
            check_eq("end_busy", 32'(busy), 0);
            check_eq("end_data_keep", 32'(data_out), 32'(cur.word));
            last_word = cur.word;
            in_flight = 1'b0;
          end
        end else begin
          if (grant != '0) begin
            if (exp_q.size() == 0) begin
              check_eq("unexpected_grant", 32'(grant), 0);
            end else begin
              cur       = exp_q.pop_front();
              in_flight = 1'b1;
              off       = 0;
              stb_cnt   = 0;
              check_eq("grant_winner", 32'(grant), 32'(NREQ'(1) << cur.w));
              check_eq("grant_data", 32'(data_out), 32'(cur.word));
              check_eq("setup_stb", 32'(stb_out), 0);
              check_eq("grant_busy", 32'(busy), 1);
            end
          end else begin
            check_eq("idle_done", 32'(done), 0);
            check_eq("idle_busy", 32'(busy), 0);
            check_eq("idle_stb", 32'(stb_out), 0);
            check_eq("idle_data", 32'(data_out), 32'(last_word));
          end
          if (lat_armed) begin
            check_eq("grant_latency", 32'(grant != '0), 1);
            lat_armed = 1'b0;
          end
        end
`ifdef SYNC_TX_XFER_CNT_EN
        check_eq("xfer_count", 32'(xfer_count), 32'(16'(xfer_model)));
`endif
      end
      p_grant = grant;
      p_done  = done;
      p_data  = data_out;
      p_stb   = stb_out;
      p_busy  = busy;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
    ena = rand_ena ? 1'($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  // Predict the batch order from the pointer rule, then drive requests until all dones are seen
  task automatic run_batch();
    int unsigned rem   [NREQ];
    int unsigned taken [NREQ];
    int unsigned total = 0;
    int unsigned got   = 0;
    int unsigned budget = 0;
    logic [NREQ-1:0] pg = '0;
    logic [NREQ-1:0] pd = '0;
    bit saved;
    exp_t e;
    for (int i = 0; i < NREQ; i++) begin
      rem[i]   = b_cnt[i];
      taken[i] = 0;
      total   += b_cnt[i];
    end
    for (int t = 0; t < total; t++) begin
      for (int k = 0; k < NREQ; k++) begin
        int unsigned c;
        c = (mptr + 32'(k)) % NREQ;
        if (rem[c] != 0) begin
          e.w    = 8'(c);
          e.word = b_word[c][taken[c]];
          exp_q.push_back(e);
          rem[c]--;
          taken[c]++;
          mptr = (c + 1) % NREQ;
          break;
        end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      taken[i] = 0;
      req_data[i*N +: N] = b_word[i][0];
      req[i] = (b_cnt[i] != 0);
    end
    lat_armed = 1'b1;
    while (got < total && budget < 60 * total) begin
      tick();
      budget++;
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i] && !pg[i]) begin
          taken[i]++;
          req_data[i*N +: N] = (taken[i] < b_cnt[i]) ? b_word[i][taken[i]] : N'($urandom);
          if (taken[i] == b_cnt[i] && $urandom_range(0, 1) == 1) req[i] = 1'b0;
        end
        if (done[i] && !pd[i]) begin
          got++;
          if (taken[i] == b_cnt[i]) req[i] = 1'b0;
        end
      end
      pg = grant;
      pd = done;
    end
    check_eq("batch_complete", got, total);
    req   = '0;
    saved = rand_ena;
    rand_ena = 1'b0;
    repeat (3) tick();
    rand_ena = saved;
  endtask

  task automatic set_batch(input logic [NREQ-1:0] mask);
    for (int i = 0; i < NREQ; i++) begin
      b_cnt[i]     = mask[i] ? $urandom_range(1, 2) : 0;
      b_word[i][0] = N'($urandom);
      b_word[i][1] = N'($urandom);
    end
  endtask

  // Reset lands two edges into HOLD: transfer abandoned, pointer back to 0
  task automatic reset_in_hold();
    exp_t e;
    rand_ena = 1'b0;
    e.w = 8'd2;
    e.word = 8'h5A;
    exp_q.push_back(e);
    req_data[2*N +: N] = 8'h5A;
    req       = 4'b0100;
    lat_armed = 1'b1;
    repeat (5) tick();
    rst_n = 1'b0;
    req   = '0;
    tick();
    rst_n = 1'b1;
    mptr  = 0;
    repeat (12) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    ena = 1'b0;
    req = '0;
    req_data = '0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    ena = 1'b1;
    tick();

    b_cnt = '{2, 1, 1, 1};
    b_word[0][0] = 8'h11; b_word[0][1] = 8'h55;
    b_word[1][0] = 8'h22; b_word[1][1] = 8'h00;
    b_word[2][0] = 8'h33; b_word[2][1] = 8'h00;
    b_word[3][0] = 8'h44; b_word[3][1] = 8'h00;
    run_batch();

    b_cnt = '{0, 0, 1, 0};
    b_word[2][0] = 8'hA5;
    run_batch();

    b_cnt = '{0, 1, 0, 0};
    run_batch();
    b_cnt = '{0, 1, 0, 1};
    run_batch();

    rand_ena = 1'b1;
    for (int b = 0; b < 30; b++) begin
      logic [NREQ-1:0] m;
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      set_batch(m);
      run_batch();
    end

    reset_in_hold();
    b_cnt = '{1, 0, 0, 1};
    b_word[0][0] = 8'hC3;
    b_word[3][0] = 8'h3C;
    run_batch();

    repeat (4) tick();
    check_eq("queue_empty", exp_q.size(), 0);
    check_eq("none_in_flight", 32'(in_flight), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
